// File: rtl/bch_arb_pkg.sv
// bch_arb_pkg: state encoding, ID width helper and default watchdog limit
// shared by the BCH encode arbiter, its interface and its round-robin picker.
package bch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

    // Number of bits needed to index n items (minimum of 1 bit for n<=2).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/bch_encode_arbiter_if.sv
// bch_encode_arbiter_if: bundles the requester, encoder and result buses of
// the BCH encode arbiter. The master modport is the arbiter's view; slave is
// the view of the surrounding requesters/encoder/consumer.
interface bch_encode_arbiter_if
    import bch_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CODE_W  = 15,
    parameter int ID_W    = clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      enc_din_en;
    logic [DATA_W-1:0]         enc_data_in;
    logic                      enc_ready;
    logic                      enc_dout_valid;
    logic [CODE_W-1:0]         enc_data_out;
    logic                      out_valid;
    logic [CODE_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_err;
    logic                      out_ready;
    logic                      busy;

    modport master (
        input  req_valid, req_data, enc_ready, enc_dout_valid, enc_data_out, out_ready,
        output req_ready, enc_din_en, enc_data_in, out_valid, out_data, out_id, out_err, busy
    );

    modport slave (
        output req_valid, req_data, enc_ready, enc_dout_valid, enc_data_out, out_ready,
        input  req_ready, enc_din_en, enc_data_in, out_valid, out_data, out_id, out_err, busy
    );

endinterface

// File: rtl/bch_rr_picker.sv
// bch_rr_picker: purely combinational round-robin selector. Searches the
// request vector starting one past the last grant, wrapping modulo NUM_REQ
// so non-power-of-two requester counts rotate correctly.
module bch_rr_picker
    import bch_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_lastGrant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand;

    // First requesting slot after the previous winner becomes the one-hot grant.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((int'(i_lastGrant) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/bch_encode_arbiter.sv
// bch_encode_arbiter: shares one BCH encode wrapper between NUM_REQ
// requesters. Takes one word from the round-robin winner, pulses the encoder,
// waits for the codeword and returns it tagged with the requester ID.
// Optional watchdog in WAIT is enabled by defining BCH_ARB_TIMEOUT_EN.
module bch_encode_arbiter
    import bch_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int CODE_W         = 15,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bch_encode_arbiter_if.master bus
);

    localparam int ID_W = clog2(NUM_REQ);

    // Reject configurations the round-robin index and watchdog cannot support.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_badNumReq
            $error("bch_encode_arbiter: NUM_REQ must be within 2..16");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
            $error("bch_encode_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_nextState;
    logic [ID_W-1:0]    r_lastGrant;
    logic [ID_W-1:0]    r_id;
    logic [DATA_W-1:0]  r_encData;
    logic               r_outValid;
    logic [CODE_W-1:0]  r_outData;
    logic [ID_W-1:0]    r_outId;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grantIdx;
    logic               w_grantAny;
    logic               w_take;
    logic [DATA_W-1:0]  w_grantData;
    logic               w_expire;

    bch_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req       (bus.req_valid),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant),
        .o_idx       (w_grantIdx),
        .o_any       (w_grantAny)
    );

    // A grant is only offered while idle and the encoder reports ready.
    assign w_take = (r_state == IDLE) && bus.enc_ready && w_grantAny;

    // Select the winning requester's word from the flattened data bus.
    always_comb begin
        w_grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantIdx == ID_W'(i)) begin
                w_grantData = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BCH_ARB_TIMEOUT_EN
    localparam int TIMER_W = clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] r_timer;
    logic               r_outErr;

    assign w_expire = (r_state == WAIT) && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles; a real codeword on the expiry edge still wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timer  <= '0;
            r_outErr <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_timer <= '0;
            end else if (r_state == WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == WAIT && bus.enc_dout_valid) begin
                r_outErr <= 1'b0;
            end else if (w_expire) begin
                r_outErr <= 1'b1;
            end
        end
    end

    assign bus.out_err = r_outErr;
`else
    assign w_expire    = 1'b0;
    assign bus.out_err = 1'b0;
`endif

    // Next-state logic: grant, single-cycle issue, wait for codeword, hold until accepted.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_take) w_nextState = ISSUE;
            ISSUE:   w_nextState = WAIT;
            WAIT:    if (bus.enc_dout_valid || w_expire) w_nextState = DELIVER;
            DELIVER: if (bus.out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State register plus the grant and result datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_lastGrant <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_encData   <= '0;
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outId     <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_encData   <= w_grantData;
                        r_id        <= w_grantIdx;
                        r_lastGrant <= w_grantIdx;
                    end
                end
                WAIT: begin
                    if (bus.enc_dout_valid) begin
                        r_outValid <= 1'b1;
                        r_outData  <= bus.enc_data_out;
                        r_outId    <= r_id;
                    end else if (w_expire) begin
                        r_outValid <= 1'b1;
                        r_outData  <= '0;
                        r_outId    <= r_id;
                    end
                end
                DELIVER: begin
                    if (bus.out_ready) r_outValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = w_take ? w_grant : '0;
    assign bus.enc_din_en  = (r_state == ISSUE);
    assign bus.enc_data_in = r_encData;
    assign bus.out_valid   = r_outValid;
    assign bus.out_data    = r_outData;
    assign bus.out_id      = r_outId;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_bch_encode_arbiter.sv
// tb_bch_encode_arbiter: directed stimulus with a decoupled scoreboard for
// the BCH encode arbiter. Stimulus pushes expected grants, issued words and
// results; one monitor pops and compares whenever the DUT presents them.
// Timeout scenarios run when BCH_ARB_TIMEOUT_EN is defined.
module tb_bch_encode_arbiter;

`ifdef BCH_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [14:0] data;
        logic        err;
    } out_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    int         expGrant[$];
    logic [7:0] expIssue[$];
    out_t       expOut[$];

    logic [14:0] rrCode [5] = '{15'h0101, 15'h0202, 15'h0303, 15'h0404, 15'h7E01};

    bch_encode_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .CODE_W(15)) bus ();

    bch_encode_arbiter #(
        .NUM_REQ        (4),
        .DATA_W         (8),
        .CODE_W         (15),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        bus.req_valid = valid;
        bus.req_data  = data;
    endtask

    task automatic pushExpect(input int grant, input logic [7:0] word, input logic [14:0] code,
                              input logic err, input bit withOut);
        out_t o;
        expGrant.push_back(grant);
        expIssue.push_back(word);
        if (withOut) begin
            o.id   = 2'(grant);
            o.data = code;
            o.err  = err;
            expOut.push_back(o);
        end
    endtask

    // Wait (bounded) for the encoder start pulse; returns at that negedge.
    task automatic waitIssue();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = bus.enc_din_en;
        end
        checkOutput("issue_seen", 32'(seen), 32'd1);
    endtask

    // Behave as the encoder: answer the start pulse after `lat` cycles.
    task automatic serveEncode(input logic [14:0] code, input int lat);
        waitIssue();
        repeat (lat) @(negedge clk);
        bus.enc_dout_valid = 1'b1;
        bus.enc_data_out   = code;
        @(negedge clk);
        bus.enc_dout_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 50 && bus.busy; n++) @(negedge clk);
        checkOutput("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard monitor: grants, encoder issues and accepted results.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (bus.req_ready != 4'b0) begin
                    checkOutput("grant_expected", 32'(expGrant.size() != 0), 32'd1);
                    if (expGrant.size() != 0) begin
                        int g;
                        g = expGrant.pop_front();
                        checkOutput("grant_onehot", 32'(bus.req_ready), 32'(4'b0001 << g));
                    end
                end
                if (bus.enc_din_en) begin
                    checkOutput("issue_expected", 32'(expIssue.size() != 0), 32'd1);
                    if (expIssue.size() != 0) begin
                        logic [7:0] w;
                        w = expIssue.pop_front();
                        checkOutput("issue_data", 32'(bus.enc_data_in), 32'(w));
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checkOutput("out_expected", 32'(expOut.size() != 0), 32'd1);
                    if (expOut.size() != 0) begin
                        out_t o;
                        o = expOut.pop_front();
                        checkOutput("out_id", 32'(bus.out_id), 32'(o.id));
                        checkOutput("out_data", 32'(bus.out_data), 32'(o.data));
                        checkOutput("out_err", 32'(bus.out_err), 32'(o.err));
                    end
                end
            end
        end
    end

    // Hard stop if the run stalls somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        reset_n            = 1'b0;
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.enc_ready      = 1'b1;
        bus.enc_dout_valid = 1'b0;
        bus.enc_data_out   = '0;
        bus.out_ready      = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_din_en", 32'(bus.enc_din_en), 32'd0);
        checkOutput("rst_out_err", 32'(bus.out_err), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_id", 32'(bus.out_id), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);

        // Single request from requester 2.
        @(negedge clk);
        pushExpect(2, 8'hA5, 15'h1234, 1'b0, 1'b1);
        applyStimulus(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        serveEncode(15'h1234, 2);
        applyStimulus(4'b0000, 32'h0);
        waitIdle();

        // Reset while waiting on the encoder; late codeword must be dropped.
        @(negedge clk);
        pushExpect(3, 8'hC3, 15'h0, 1'b0, 1'b0);
        applyStimulus(4'b1000, {8'hC3, 24'h0});
        waitIssue();
        applyStimulus(4'b0000, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("mid_busy_wait", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n            = 1'b1;
        bus.enc_dout_valid = 1'b1;
        bus.enc_data_out   = 15'h5555;
        @(negedge clk);
        bus.enc_dout_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            checkOutput("mid_no_out", {bus.out_valid, bus.busy}, 32'd0);
        end

        // All requesters valid: rotation restarts at 0 after reset.
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            pushExpect(k % 4, 8'(8'h10 + (k % 4)), rrCode[k], 1'b0, 1'b1);
        end
        applyStimulus(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        for (int k = 0; k < 5; k++) begin
            serveEncode(rrCode[k], 1 + (k % 3));
        end
        applyStimulus(4'b0000, 32'h0);
        waitIdle();

        // Backpressure: result held, no new grants while out_ready is low.
        @(negedge clk);
        pushExpect(1, 8'h3C, 15'h7ABC, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        applyStimulus(4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00});
        serveEncode(15'h7ABC, 3);
        applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_hold", {bus.out_valid, bus.out_data, bus.out_id, bus.req_ready},
                        {1'b1, 15'h7ABC, 2'd1, 4'b0000});
        end
        @(negedge clk);
        applyStimulus(4'b0000, 32'h0);
        bus.out_ready = 1'b1;
        waitIdle();

        // Encoder not ready: no grant; stray codeword in IDLE ignored.
        @(negedge clk);
        bus.enc_ready = 1'b0;
        applyStimulus(4'b0001, {24'h0, 8'h5A});
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            checkOutput("nordy_hold", {bus.req_ready, bus.enc_din_en, bus.busy}, 32'd0);
        end
        @(negedge clk);
        bus.enc_dout_valid = 1'b1;
        bus.enc_data_out   = 15'h7FFF;
        @(negedge clk);
        bus.enc_dout_valid = 1'b0;
        #1;
        checkOutput("stray_no_out", {bus.out_valid, bus.busy}, 32'd0);
        @(negedge clk);
        pushExpect(0, 8'h5A, 15'h0F0F, 1'b0, 1'b1);
        bus.enc_ready = 1'b1;
        serveEncode(15'h0F0F, 2);
        applyStimulus(4'b0000, 32'h0);
        waitIdle();

`ifdef BCH_ARB_TIMEOUT_EN
        // No codeword: error result after exactly TO WAIT cycles.
        @(negedge clk);
        pushExpect(2, 8'h77, 15'h0, 1'b1, 1'b1);
        applyStimulus(4'b0100, {8'h00, 8'h77, 16'h0});
        waitIssue();
        applyStimulus(4'b0000, 32'h0);
        repeat (TO) @(negedge clk);
        #1;
        checkOutput("to_before", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("to_after", {bus.out_valid, bus.out_err}, 32'd3);
        waitIdle();

        // Codeword on the expiry cycle wins over the timeout.
        @(negedge clk);
        pushExpect(3, 8'h88, 15'h2AAA, 1'b0, 1'b1);
        applyStimulus(4'b1000, {8'h88, 24'h0});
        serveEncode(15'h2AAA, TO);
        applyStimulus(4'b0000, 32'h0);
        waitIdle();
`endif

        repeat (3) @(negedge clk);
        checkOutput("grant_q_drained", 32'(expGrant.size()), 32'd0);
        checkOutput("issue_q_drained", 32'(expIssue.size()), 32'd0);
        checkOutput("out_q_drained", 32'(expOut.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_encode_arbiter.md
Name: bch_encode_arbiter

Overview:
Shares one BCH encode wrapper instance between NUM_REQ independent requesters using round-robin arbitration.
- Accepts one data word from the granted requester, launches one encode, and waits for the codeword.
- Returns the codeword tagged with the requester ID on a valid/ready output port.
- Sits directly in front of the encode wrapper. All encoder sequencing (din_en pulse, completion wait) is owned by this block.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, message width; must equal the encoder's BCH data bits
CODE_W, 15, codeword width; must equal the encoder's BCH code bits
TIMEOUT_CYCLES, 1023, watchdog limit in WAIT state (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_W  flattened words; requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant; word i is taken when req_valid[i] and req_ready[i] are both high
enc_din_en  out  1  one-cycle start pulse to the encoder
enc_data_in  out  DATA_W  message to the encoder; held stable from ISSUE until the next grant
enc_ready  in  1  encoder idle/ready
enc_dout_valid  in  1  encoder codeword-complete pulse
enc_data_out  in  CODE_W  encoder codeword
out_valid  out  1  result valid
out_data  out  CODE_W  codeword
out_id  out  clog2(NUM_REQ)  ID of the requester that produced the result
out_err  out  1  result is a timeout error (constant 0 without the optional feature)
out_ready  in  1  downstream accept
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at an edge) gives: state=IDLE, req_ready=0, enc_din_en=0, out_valid=0, out_err=0, out_data=0, out_id=0, last_grant=NUM_REQ-1. Requester 0 therefore wins first.
- Reset mid-operation aborts the in-flight encode. Any later enc_dout_valid is ignored because it arrives outside WAIT.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: when enc_ready=1 and any req_valid is set, pick g = first set bit searching from last_grant+1 with wrap modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle; all other bits are 0.
  - Latch req_data[g] into enc_data_in and g into the ID register; set last_grant=g; go to ISSUE.
  - No grant is issued if enc_ready=0.
- ISSUE: enc_din_en=1 for exactly this one cycle; next state is WAIT.
- WAIT: enc_ready is ignored. On enc_dout_valid=1, register out_data=enc_data_out, out_id=ID, out_valid=1, out_err=0, and go to DELIVER.
- DELIVER: out_valid, out_data, out_id and out_err are held stable until out_ready=1. On that accept edge out_valid=0 and the next state is IDLE.
- Back-to-back operation: a new grant is possible in the cycle after the DELIVER accept. Minimum per-word occupancy is 1 (grant) + 1 (ISSUE) + encoder latency + 1 (DELIVER).
- enc_dout_valid in IDLE, ISSUE or DELIVER is ignored (no state change).
- req_valid deasserted before grant: no effect. The request is not remembered.
- Round-robin fairness: with all requesters continuously valid, grants run 0,1,2,3,0,... A requester waits at most NUM_REQ-1 other grants.
- Widths: the round-robin index wraps with explicit modulo NUM_REQ, because NUM_REQ need not be a power of 2.

Optional Feature:
- Macro: BCH_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without enc_dout_valid, go to DELIVER with out_err=1, out_data=0, out_id=ID.
  - enc_dout_valid in the same cycle as expiry wins: a normal result is produced.
- Undefined: no counter; WAIT lasts indefinitely; out_err is tied to 0.

Decomposition:
- Package bch_arb_pkg holds:
  - the state encoding constants (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3, 2-bit)
  - a clog2 function for the ID width
  - the default TIMEOUT_CYCLES.
- One sub-module, bch_rr_picker: purely combinational. Inputs are the req vector and last_grant; outputs are the one-hot grant and its index. All registers stay in bch_encode_arbiter.

Test Plan:
- Reset mid-flight: assert reset_n=0 during WAIT, then pulse enc_dout_valid -> out_valid stays 0, state returns to IDLE, and the next grant goes to requester 0.
- Single request: req_valid=4'b0100, data 8'hA5, enc_ready=1 -> req_ready=4'b0100 for 1 cycle; enc_din_en pulses the next cycle with enc_data_in=8'hA5; enc_dout_valid with 15'h1234 -> out_valid=1, out_data=15'h1234, out_id=2.
- All four requesters valid continuously with out_ready=1 -> grant order 0,1,2,3,0 and out_id sequence matches.
- Backpressure: out_ready=0 for 10 cycles in DELIVER -> out_valid/out_data/out_id stable and no new req_ready; out_ready=1 -> accept, then IDLE.
- enc_ready=0 while req_valid=4'b0001 -> no grant and no enc_din_en until enc_ready=1. A stray enc_dout_valid in IDLE produces no output.
- With BCH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no enc_dout_valid -> out_valid=1, out_err=1, out_data=0 after 8 WAIT cycles. With enc_dout_valid exactly on cycle 8 -> out_err=0.
